// File: rtl/mips_pkg.sv
// Shared definitions for the MEM stage: access-size codes, control-field bit
// positions inside regMEM/regWB, and default datapath widths.
package mips_pkg;

   localparam int NB_DATA_DEF = 32;
   localparam int NB_REG_DEF  = 5;

   typedef enum logic [1:0] {
      SZ_BYTE     = 2'b00,
      SZ_HALF     = 2'b01,
      SZ_WORD     = 2'b10,
      SZ_WORD_ALT = 2'b11
   } mem_size_e;

   // regMEM = {MemRead, MemWrite, Unsigned, Size[0]}
   localparam int RM_MEMREAD  = 3;
   localparam int RM_MEMWRITE = 2;
   localparam int RM_UNSIGNED = 1;
   localparam int RM_SIZE0    = 0;

   // regWB = {Size[1], RegWrite, MemtoReg}
   localparam int RW_SIZE1    = 2;
   localparam int RW_REGWRITE = 1;
   localparam int RW_MEMTOREG = 0;

   // Size 11 behaves as a word, so size[1] alone identifies word accesses.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
      return ((size == SZ_HALF) && lane[0]) || (size[1] && (lane != 2'b00));
   endfunction

endpackage

// File: rtl/data_memory.sv
// Word-organised synchronous data memory with per-byte-lane write enables and a
// registered read port that holds its value whenever rd_en is low.
module data_memory
   import mips_pkg::*;
#(
   parameter int NB_DATA     = NB_DATA_DEF,
   parameter int NB_MEM_ADDR = 8
) (
   input  logic                   clk,
   input  logic [NB_DATA/8-1:0]   we,
   input  logic [NB_MEM_ADDR-1:0] wr_addr,
   input  logic [NB_DATA-1:0]     wr_data,
   input  logic                   rd_en,
   input  logic [NB_MEM_ADDR-1:0] rd_addr,
   output logic [NB_DATA-1:0]     rd_data
);

   localparam int NB_LANES = NB_DATA / 8;

   logic [NB_DATA-1:0] mem [2**NB_MEM_ADDR];

   always_ff @(posedge clk) begin
      for (int i = 0; i < NB_LANES; i++) begin
         if (we[i]) mem[wr_addr][i*8 +: 8] <= wr_data[i*8 +: 8];
      end
      if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: EX/MEM register, byte-addressable data memory access and MEM/WB
// register, with load alignment/extension and forwarding outputs.
module mem_stage
   import mips_pkg::*;
#(
   parameter int NB_DATA     = NB_DATA_DEF,
   parameter int NB_REG      = NB_REG_DEF,
   parameter int NB_MEM_ADDR = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_stall,
   input  logic              i_flush,
   input  logic [NB_DATA-1:0] in_ALU,
   input  logic [NB_DATA-1:0] in_wrd,
   input  logic [NB_REG-1:0]  in_addr_dest,
   input  logic [3:0]        in_regMEM,
   input  logic [2:0]        in_regWB,
   output logic [NB_DATA-1:0] ex_mem_ALU,
   output logic [NB_REG-1:0]  ex_mem_addr_dest,
   output logic              ex_mem_RegWrite,
   output logic [NB_REG-1:0]  mem_wb_addr_dest,
   output logic              mem_wb_RegWrite,
   output logic [NB_DATA-1:0] WB_mux,
   output logic              out_misalign
);

   function automatic logic [NB_DATA-1:0] load_extend(input logic [NB_DATA-1:0] word,
                                                      input logic [1:0] lane,
                                                      input logic [1:0] size,
                                                      input logic uns);
      logic [7:0]  b;
      logic [15:0] h;
      b = word[{lane, 3'b000} +: 8];
      h = lane[1] ? word[31:16] : word[15:0];
      case (size)
         SZ_BYTE: return uns ? {{(NB_DATA-8){1'b0}}, b}  : {{(NB_DATA-8){b[7]}}, b};
         SZ_HALF: return uns ? {{(NB_DATA-16){1'b0}}, h} : {{(NB_DATA-16){h[15]}}, h};
         default: return word;
      endcase
   endfunction

   // ---- EX/MEM register (p0) ----
   logic [NB_DATA-1:0] alu_p0, wrd_p0;
   logic [NB_REG-1:0]  dest_p0;
   logic [1:0]         size_p0;
   logic               mem_read_p0, mem_write_p0, uns_p0, reg_write_p0, memto_reg_p0;

   always_ff @(posedge clk) begin
      if (reset) begin
         alu_p0       <= '0;
         wrd_p0       <= '0;
         dest_p0      <= '0;
         size_p0      <= '0;
         uns_p0       <= 1'b0;
         mem_read_p0  <= 1'b0;
         mem_write_p0 <= 1'b0;
         reg_write_p0 <= 1'b0;
         memto_reg_p0 <= 1'b0;
      end else if (i_flush || !i_stall) begin
         alu_p0       <= in_ALU;
         wrd_p0       <= in_wrd;
         dest_p0      <= in_addr_dest;
         size_p0      <= {in_regWB[RW_SIZE1], in_regMEM[RM_SIZE0]};
         uns_p0       <= in_regMEM[RM_UNSIGNED];
         mem_read_p0  <= !i_flush && in_regMEM[RM_MEMREAD];
         mem_write_p0 <= !i_flush && in_regMEM[RM_MEMWRITE];
         reg_write_p0 <= !i_flush && in_regWB[RW_REGWRITE];
         memto_reg_p0 <= !i_flush && in_regWB[RW_MEMTOREG];
      end
   end

   // ---- memory access (cycle after EX/MEM capture) ----
   logic [1:0]             lane_p0;
   logic                   mis_p0, wr_ok_p0, rd_ok_p0;
   logic [3:0]             be_p0, we_p0;
   logic [NB_DATA-1:0]     wr_data_p0, rd_data_p1;
   logic [NB_MEM_ADDR-1:0] word_idx_p0;

   assign lane_p0     = alu_p0[1:0];
   assign word_idx_p0 = alu_p0[NB_MEM_ADDR+1:2];
   assign mis_p0      = (mem_read_p0 || mem_write_p0) && is_misaligned(size_p0, lane_p0);
   // A stalled store stays in EX/MEM, so it writes only on the edge that releases it.
   assign wr_ok_p0    = mem_write_p0 && !mis_p0 && !i_stall && !reset;
   assign rd_ok_p0    = mem_read_p0  && !mis_p0 && !i_stall && !reset;
   assign we_p0       = wr_ok_p0 ? be_p0 : 4'b0000;

   always_comb begin
      be_p0      = 4'b1111;
      wr_data_p0 = wrd_p0;
      case (size_p0)
         SZ_BYTE: begin
            be_p0      = 4'b0001 << lane_p0;
            wr_data_p0 = {4{wrd_p0[7:0]}};
         end
         SZ_HALF: begin
            be_p0      = lane_p0[1] ? 4'b1100 : 4'b0011;
            wr_data_p0 = {2{wrd_p0[15:0]}};
         end
         default: ;
      endcase
   end

   data_memory #(
      .NB_DATA     (NB_DATA),
      .NB_MEM_ADDR (NB_MEM_ADDR)
   ) u_data_memory (
      .clk     (clk),
      .we      (we_p0),
      .wr_addr (word_idx_p0),
      .wr_data (wr_data_p0),
      .rd_en   (rd_ok_p0),
      .rd_addr (word_idx_p0),
      .rd_data (rd_data_p1)
   );

   // ---- MEM/WB register (p1) ----
   logic [NB_DATA-1:0] alu_p1, load_data_p1;
   logic [NB_REG-1:0]  dest_p1;
   logic [1:0]         size_p1, lane_p1;
   logic               uns_p1, load_p1, mis_p1, reg_write_p1, memto_reg_p1;

   always_ff @(posedge clk) begin
      if (reset) begin
         alu_p1       <= '0;
         dest_p1      <= '0;
         size_p1      <= '0;
         lane_p1      <= '0;
         uns_p1       <= 1'b0;
         load_p1      <= 1'b0;
         mis_p1       <= 1'b0;
         reg_write_p1 <= 1'b0;
         memto_reg_p1 <= 1'b0;
      end else if (!i_stall) begin
         alu_p1       <= alu_p0;
         dest_p1      <= dest_p0;
         size_p1      <= size_p0;
         lane_p1      <= lane_p0;
         uns_p1       <= uns_p0;
         load_p1      <= mem_read_p0 && !mis_p0;
         mis_p1       <= mis_p0;
         reg_write_p1 <= reg_write_p0;
         memto_reg_p1 <= memto_reg_p0;
      end
   end

   // Read data is only meaningful for a real, aligned load; otherwise it reads as 0.
   assign load_data_p1 = load_p1 ? load_extend(rd_data_p1, lane_p1, size_p1, uns_p1) : '0;

   assign ex_mem_ALU       = alu_p0;
   assign ex_mem_addr_dest = dest_p0;
   assign ex_mem_RegWrite  = reg_write_p0;
   assign mem_wb_addr_dest = dest_p1;
   assign mem_wb_RegWrite  = reg_write_p1;
   assign WB_mux           = memto_reg_p1 ? load_data_p1 : alu_p1;
   assign out_misalign     = mis_p1;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a byte-array reference model predicts each
// MEM/WB entry at issue time; an independent monitor checks entries as they land.
module tb_mem_stage;

   logic        clk;
   logic        reset;
   logic        i_stall;
   logic        i_flush;
   logic [31:0] in_ALU;
   logic [31:0] in_wrd;
   logic [4:0]  in_addr_dest;
   logic [3:0]  in_regMEM;
   logic [2:0]  in_regWB;
   logic [31:0] ex_mem_ALU;
   logic [4:0]  ex_mem_addr_dest;
   logic        ex_mem_RegWrite;
   logic [4:0]  mem_wb_addr_dest;
   logic        mem_wb_RegWrite;
   logic [31:0] WB_mux;
   logic        out_misalign;

   mem_stage dut (
      .clk              (clk),
      .reset            (reset),
      .i_stall          (i_stall),
      .i_flush          (i_flush),
      .in_ALU           (in_ALU),
      .in_wrd           (in_wrd),
      .in_addr_dest     (in_addr_dest),
      .in_regMEM        (in_regMEM),
      .in_regWB         (in_regWB),
      .ex_mem_ALU       (ex_mem_ALU),
      .ex_mem_addr_dest (ex_mem_addr_dest),
      .ex_mem_RegWrite  (ex_mem_RegWrite),
      .mem_wb_addr_dest (mem_wb_addr_dest),
      .mem_wb_RegWrite  (mem_wb_RegWrite),
      .WB_mux           (WB_mux),
      .out_misalign     (out_misalign)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] wb;
      logic        rw;
      logic [4:0]  dest;
      logic        mis;
   } exp_t;

   exp_t       sbq[$];
   logic [7:0] ref_mem [0:1023];
   int         n_cmp = 0;
   int         n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   // Reference: memory is a flat byte array; an access covers nbytes consecutive bytes.
   task automatic model_op(input logic mr, input logic mw, input logic uns, input logic [1:0] sz,
                           input logic rw, input logic mtr, input logic [31:0] alu,
                           input logic [31:0] wrd, input logic [4:0] dest);
      int          nbytes;
      int          base;
      logic        mis;
      logic [31:0] ld;
      exp_t        e;
      nbytes = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
      mis    = (mr || mw) && ((int'(alu[1:0]) % nbytes) != 0);
      base   = int'(alu[9:0]);
      if (mw && !mis)
         for (int k = 0; k < nbytes; k++) ref_mem[base + k] = wrd[8*k +: 8];
      ld = 32'h0;
      if (mr && !mis) begin
         for (int k = 0; k < nbytes; k++) ld[8*k +: 8] = ref_mem[base + k];
         if (!uns && nbytes < 4 && ld[8*nbytes-1]) ld = ld | (32'hFFFF_FFFF << (8*nbytes));
      end
      e.wb   = mtr ? ld : alu;
      e.rw   = rw;
      e.dest = dest;
      e.mis  = mis;
      sbq.push_back(e);
   endtask

   task automatic step(input logic mr, input logic mw, input logic uns, input logic [1:0] sz,
                       input logic rw, input logic mtr, input logic [31:0] alu,
                       input logic [31:0] wrd, input logic [4:0] dest,
                       input logic stall, input logic flush, input logic rst);
      exp_t z;
      in_ALU       = alu;
      in_wrd       = wrd;
      in_addr_dest = dest;
      in_regMEM    = {mr, mw, uns, sz[0]};
      in_regWB     = {sz[1], rw, mtr};
      i_stall      = stall;
      i_flush      = flush;
      reset        = rst;
      @(posedge clk);
      #1;
      if (rst) begin
         sbq.delete();
         z.wb = 32'h0; z.rw = 1'b0; z.dest = 5'd0; z.mis = 1'b0;
         sbq.push_back(z);
      end else if (flush) begin
         model_op(1'b0, 1'b0, uns, sz, 1'b0, 1'b0, alu, wrd, dest);
      end else if (!stall) begin
         model_op(mr, mw, uns, sz, rw, mtr, alu, wrd, dest);
      end
   endtask

   task automatic nop(input logic stall);
      step(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, stall, 1'b0, 1'b0);
   endtask

   task automatic sw(input logic [31:0] a, input logic [31:0] d);
      step(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, a, d, 5'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic ld(input logic [31:0] a, input logic [1:0] sz, input logic uns, input logic [4:0] dest);
      step(1'b1, 1'b0, uns, sz, 1'b1, 1'b1, a, 32'h0, dest, 1'b0, 1'b0, 1'b0);
   endtask

   // Monitor: every edge that is neither reset nor stalled moves one entry into MEM/WB.
   initial begin
      logic adv, rs;
      exp_t e;
      forever begin
         @(posedge clk);
         adv = !reset && !i_stall;
         rs  = reset;
         @(negedge clk);
         if (rs) begin
            check("reset_outputs",
                  {ex_mem_ALU ^ WB_mux, 1'b0, ex_mem_addr_dest, ex_mem_RegWrite,
                   mem_wb_addr_dest, mem_wb_RegWrite, out_misalign} | {31'h0, |ex_mem_ALU},
                  32'h0);
         end else if (adv) begin
            n_cmp++;
            if (sbq.size() == 0) begin
               n_bad++;
               $display("FAIL mem_wb_entry: DUT advanced with no expected entry queued");
            end else begin
               e = sbq.pop_front();
               if (WB_mux !== e.wb || mem_wb_RegWrite !== e.rw ||
                   mem_wb_addr_dest !== e.dest || out_misalign !== e.mis) begin
                  n_bad++;
                  $display("FAIL mem_wb_entry: got wb=%h rw=%b dest=%0d mis=%b, required wb=%h rw=%b dest=%0d mis=%b",
                           WB_mux, mem_wb_RegWrite, mem_wb_addr_dest, out_misalign,
                           e.wb, e.rw, e.dest, e.mis);
               end
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic        mr, mw, uns, rw, mtr, stall, flush;
      logic [1:0]  sz;
      logic [31:0] a;
      int          kind;

      reset = 1'b1; i_stall = 1'b0; i_flush = 1'b0;
      in_ALU = 32'h0; in_wrd = 32'h0; in_addr_dest = 5'd0; in_regMEM = 4'h0; in_regWB = 3'h0;
      step(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1);

      for (int w = 0; w < 16; w++) sw(32'(w * 4), $urandom);

      // Directed load/store patterns
      sw(32'h10, 32'hDEAD_BEEF);
      ld(32'h10, 2'b10, 1'b0, 5'd3);
      ld(32'h11, 2'b00, 1'b0, 5'd4);
      ld(32'h11, 2'b00, 1'b1, 5'd5);
      ld(32'h12, 2'b01, 1'b0, 5'd6);
      step(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 32'h13, 32'h0000_0055, 5'd0, 1'b0, 1'b0, 1'b0);
      ld(32'h10, 2'b10, 1'b0, 5'd7);
      ld(32'h06, 2'b10, 1'b0, 5'd8);
      sw(32'h06, 32'h1234_5678);
      ld(32'h04, 2'b10, 1'b0, 5'd9);

      // Store held by stall, then released
      sw(32'h24, 32'hA5A5_5A5A);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, 1'b0, 2'b10, 1'b1, 1'b1, 32'h30, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0);
         check("stall_hold_ex_mem_ALU", ex_mem_ALU, 32'h24);
      end
      ld(32'h24, 2'b10, 1'b0, 5'd10);

      // Flushed store must not write
      step(1'b0, 1'b1, 1'b0, 2'b10, 1'b1, 1'b0, 32'h20, 32'hCAFE_F00D, 5'd11, 1'b0, 1'b1, 1'b0);
      check("flush_ex_mem_RegWrite", {31'h0, ex_mem_RegWrite}, 32'h0);
      check("flush_ex_mem_ALU", ex_mem_ALU, 32'h20);
      ld(32'h20, 2'b10, 1'b0, 5'd12);

      // Randomized traffic over 16 words with wrapping upper address bits
      for (int i = 0; i < 600; i++) begin
         kind  = int'($urandom_range(0, 3));
         sz    = 2'($urandom_range(0, 3));
         uns   = 1'($urandom);
         a     = ($urandom & 32'hFFFF_FC00) | ($urandom & 32'h0000_003F);
         mr    = (kind == 1);
         mw    = (kind == 2);
         rw    = (kind == 3) ? 1'b1 : 1'($urandom);
         mtr   = mr ? 1'($urandom_range(0, 3) != 0) : 1'b0;
         stall = ($urandom_range(0, 4) == 0);
         flush = !stall && ($urandom_range(0, 9) == 0);
         step(mr, mw, uns, sz, rw, mtr, a, $urandom, 5'($urandom), stall, flush, 1'b0);
      end

      // Reset with a load sitting in EX/MEM
      ld(32'h10, 2'b10, 1'b0, 5'd7);
      step(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1);
      nop(1'b0);
      ld(32'h24, 2'b10, 1'b0, 5'd13);
      nop(1'b0);
      nop(1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
